wired_fcc_iq: RTL and testbench
===============================

Name: wired_fcc_iq

Overview:
- In-order issue queue directly upstream of the FCC execution engine; buffers fcc-class ops (fcmp, fsel, fclass, movxr2cf, movcf2xr, bceqz/bcnez) from dispatch.
- Captures late source operands from the writeback wakeup bus.
- Issues strictly in program order to the engine through a valid/ready handshake.
- Cleared completely on pipeline flush, in step with the engine's fcc reload.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- WKUP_PORTS, 2, number of writeback wakeup/data ports.
- RID_W, 6, physical register tag width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; drops all entries.
- dp_valid_i  in  1  dispatch request.
- dp_ready_o  out  1  queue can accept this cycle.
- dp_req_i  in  $bits(iq_fcc_req_t)  payload; r0/r1 hold operand values when the matching ready bit is set.
- dp_rid_i  in  2*RID_W  source tags {rid1, rid0}.
- dp_rdy_i  in  2  source ready bits {rdy1, rdy0}; ops without a source dispatch with the bit set.
- wkup_valid_i  in  WKUP_PORTS  wakeup strobes.
- wkup_rid_i  in  WKUP_PORTS*RID_W  wakeup tags.
- wkup_data_i  in  WKUP_PORTS*32  wakeup data.
- ex_req_valid_o  out  1  head entry is issuable.
- ex_req_ready_i  in  1  FCC engine accepts.
- ex_req_o  out  $bits(iq_fcc_req_t)  head payload with captured operands.

Behaviour:
- Storage: circular buffer with head/tail pointers of clog2(DEPTH)+1 bits; the extra bit is the wrap bit.
  - Empty: head==tail.
  - Full: index bits equal and wrap bits differ.
  - Count is derived from the pointers, not stored separately.
- Each entry holds: payload, rid0/rid1, rdy0/rdy1.
- Dispatch:
  - dp_ready_o = !full; it does not depend on the same-cycle issue.
  - Accept when dp_valid_i && dp_ready_o && !flush_i. Write the entry at tail, then tail+1.
- Write-time bypass: a source arriving with rdy=0 is checked against the same-cycle wakeup bus.
  - On a tag match, rdy is stored as 1 and r0/r1 as the wakeup data.
  - This prevents missing a wakeup that coincides with dispatch.
- Wakeup capture:
  - For every stored entry, each source with rdy=0 compares against all ports.
  - On a match: next-cycle rdy=1 and the operand field takes that port's data.
  - If several ports match, the lowest port index wins.
  - A source with rdy=1 never changes again.
- Issue:
  - ex_req_valid_o = !empty && head.rdy0 && head.rdy1.
  - It is driven from registered state only; there is no combinational path from wkup_* or dp_* to ex_req_*.
  - ex_req_o is the head payload.
  - A wakeup to the head in cycle t gives issue-valid in cycle t+1.
  - Minimum dispatch-to-issue latency is 1 cycle, with the entry dispatched into an empty queue.
- Handshake:
  - Pop when ex_req_valid_o && ex_req_ready_i && !flush_i; head then advances by 1.
  - While valid && !ready, ex_req_o and valid hold stable, because the head sources are already ready.
- Simultaneous events:
  - Push and pop in the same cycle: both occur and occupancy is unchanged.
  - A full queue with a same-cycle pop still reports dp_ready_o=0; the conservative choice is intentional.
- Flush:
  - flush_i has priority over push, pop and wakeup.
  - Next cycle: head=tail=0, the queue is empty, ex_req_valid_o=0 and dp_ready_o=1.
  - Entry contents are don't-care.
- Reset: same effect as flush.
  - Every output after reset: ex_req_valid_o=0, dp_ready_o=1, ex_req_o=don't-care.
  - Reset asserted mid-stream discards all entries, including a held head.
- Pointer wrap: index arithmetic is modulo DEPTH and the wrap bit toggles on each rollover. No entry is lost at the wrap.

Decomposition:
- Shared defines header, next to iq_fcc_req_t:
  - fcc_iq_entry_t: payload, rid[2], rdy[2].
  - wkup_t: valid, rid, data.
- Sub-module wired_fcc_iq_entry: a single entry's storage plus wakeup compare/capture, including the write-time bypass. It is instantiated DEPTH times.
- The top level owns the pointers, full/empty logic and the head mux.

Test Plan:
- Reset, then dispatch one op with rdy=2'b11 and ex_req_ready_i=1 -> ex_req_valid_o=1 the next cycle with the payload intact; queue empty after the pop.
- Dispatch fcmp with rdy0=0, rid0=5; wakeup port 1 rid=5, data=32'h3f800000 two cycles later -> valid rises the cycle after the wakeup, with ex_req_o.r0=32'h3f800000.
- Dispatch rdy1=0, rid1=9 in the same cycle as wakeup rid=9, data=32'h40000000 -> the entry is stored ready and issues the next cycle with r1=32'h40000000.
- Hold ex_req_ready_i=0 and dispatch 4 ops -> dp_ready_o=0 after the 4th. Then release ready for 8 cycles with back-to-back dispatch -> program order preserved across the pointer wrap, no drop or duplicate.
- Head blocked on rdy0=0 while entry 2 is fully ready -> entry 2 does not issue; issue order remains 1 then 2 after the head's wakeup.
- Full queue with valid held; assert flush_i in the same cycle as a dispatch -> next cycle ex_req_valid_o=0, dp_ready_o=1, and the dispatched op is dropped.

Source files
------------

// File: rtl/wired_fcc_iq_pkg.sv
// Shared types for the FCC issue queue: op payload, per-entry state and wakeup bus beat.
package wired_fcc_iq_pkg;

    localparam int FCC_RID_W = 6;

    typedef enum logic [2:0] {
        FCC_FCMP     = 3'd0,
        FCC_FSEL     = 3'd1,
        FCC_FCLASS   = 3'd2,
        FCC_MOVXR2CF = 3'd3,
        FCC_MOVCF2XR = 3'd4,
        FCC_BCEQZ    = 3'd5,
        FCC_BCNEZ    = 3'd6
    } fcc_op_t;

    typedef struct packed {
        fcc_op_t     op;
        logic [2:0]  cd;
        logic [4:0]  cond;
        logic [31:0] r0;
        logic [31:0] r1;
    } iq_fcc_req_t;

    typedef struct packed {
        iq_fcc_req_t                req;
        logic [1:0][FCC_RID_W-1:0]  rid;
        logic [1:0]                 rdy;
    } fcc_iq_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [FCC_RID_W-1:0] rid;
        logic [31:0]          data;
    } wkup_t;

endpackage

// File: rtl/wired_fcc_iq_entry.sv
// One issue-queue slot: holds an op and captures missing operands from the wakeup bus.
// Also applies the wakeup bus to the incoming write so a coincident wakeup is never lost.
module wired_fcc_iq_entry
    import wired_fcc_iq_pkg::*;
#(
    parameter int WKUP_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  iq_fcc_req_t                       wr_req,
    input  logic [1:0][FCC_RID_W-1:0]         wr_rid,
    input  logic [1:0]                        wr_rdy,
    input  wkup_t [WKUP_PORTS-1:0]            wkup,
    output iq_fcc_req_t                       req,
    output logic [1:0]                        rdy
);

    fcc_iq_entry_t ent_q, base, ent_d;

    always_comb begin
        base = ent_q;
        if (wr_en) begin
            base.req = wr_req;
            base.rid = wr_rid;
            base.rdy = wr_rdy;
        end
        ent_d = base;
        // Scan high to low so the lowest matching port takes effect last and wins.
        for (int s = 0; s < 2; s++) begin
            if (!base.rdy[s]) begin
                for (int p = WKUP_PORTS - 1; p >= 0; p--) begin
                    if (wkup[p].valid && (wkup[p].rid == base.rid[s])) begin
                        ent_d.rdy[s] = 1'b1;
                        if (s == 0) ent_d.req.r0 = wkup[p].data;
                        else        ent_d.req.r1 = wkup[p].data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ent_q <= '0;
        else     ent_q <= ent_d;
    end

    assign req = ent_q.req;
    assign rdy = ent_q.rdy;

endmodule

// File: rtl/wired_fcc_iq.sv
// In-order issue queue in front of the FCC engine; issue-valid comes from registered state only.
// Dispatch is refused when full regardless of a same-cycle pop; flush and reset empty the queue.
module wired_fcc_iq
    import wired_fcc_iq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WKUP_PORTS = 2,
    parameter int RID_W      = FCC_RID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        dp_valid_i,
    output logic                        dp_ready_o,
    input  iq_fcc_req_t                 dp_req_i,
    input  logic [2*RID_W-1:0]          dp_rid_i,
    input  logic [1:0]                  dp_rdy_i,
    input  logic [WKUP_PORTS-1:0]       wkup_valid_i,
    input  logic [WKUP_PORTS*RID_W-1:0] wkup_rid_i,
    input  logic [WKUP_PORTS*32-1:0]    wkup_data_i,
    output logic                        ex_req_valid_o,
    input  logic                        ex_req_ready_i,
    output iq_fcc_req_t                 ex_req_o
);

    localparam int IW = $clog2(DEPTH);

    logic [IW:0]   head_q, tail_q;
    logic [IW-1:0] head_idx, tail_idx;
    logic          empty, full, push, pop;

    wkup_t [WKUP_PORTS-1:0] wkup;
    iq_fcc_req_t            ent_req [DEPTH];
    logic [1:0]             ent_rdy [DEPTH];

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

    assign dp_ready_o     = !full;
    assign push           = dp_valid_i && dp_ready_o && !flush_i;
    assign ex_req_valid_o = !empty && (&ent_rdy[head_idx]);
    assign ex_req_o       = ent_req[head_idx];
    assign pop            = ex_req_valid_o && ex_req_ready_i && !flush_i;

    always_comb begin
        for (int p = 0; p < WKUP_PORTS; p++) begin
            wkup[p].valid = wkup_valid_i[p];
            wkup[p].rid   = wkup_rid_i[p*RID_W +: RID_W];
            wkup[p].data  = wkup_data_i[p*32 +: 32];
        end
    end

    // The extra pointer bit toggles on every rollover and tells full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        wired_fcc_iq_entry #(
            .WKUP_PORTS (WKUP_PORTS)
        ) u_entry (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (push && (tail_idx == IW'(i))),
            .wr_req (dp_req_i),
            .wr_rid (dp_rid_i),
            .wr_rdy (dp_rdy_i),
            .wkup   (wkup),
            .req    (ent_req[i]),
            .rdy    (ent_rdy[i])
        );
    end

endmodule

// File: tb/tb_wired_fcc_iq.sv
// Directed bench for wired_fcc_iq: hand-computed expectations plus an in-order scoreboard for the wrap test.
module tb_wired_fcc_iq;
    import wired_fcc_iq_pkg::*;

    logic               clk = 1'b0;
    logic               rst, flush_i, dp_valid_i, dp_ready_o, ex_req_valid_o, ex_req_ready_i;
    iq_fcc_req_t        dp_req_i, ex_req_o;
    logic [11:0]        dp_rid_i;
    logic [1:0]         dp_rdy_i, wkup_valid_i;
    logic [11:0]        wkup_rid_i;
    logic [63:0]        wkup_data_i;

    int n_chk  = 0;
    int n_fail = 0;

    iq_fcc_req_t exp_q [$];
    iq_fcc_req_t r, ra, rb;
    int n_push, n_pop, seq;

    wired_fcc_iq dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .dp_valid_i     (dp_valid_i),
        .dp_ready_o     (dp_ready_o),
        .dp_req_i       (dp_req_i),
        .dp_rid_i       (dp_rid_i),
        .dp_rdy_i       (dp_rdy_i),
        .wkup_valid_i   (wkup_valid_i),
        .wkup_rid_i     (wkup_rid_i),
        .wkup_data_i    (wkup_data_i),
        .ex_req_valid_o (ex_req_valid_o),
        .ex_req_ready_i (ex_req_ready_i),
        .ex_req_o       (ex_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic iq_fcc_req_t mk(input int k);
        iq_fcc_req_t q;
        q.op   = fcc_op_t'(3'(k % 7));
        q.cd   = 3'(k);
        q.cond = 5'(k + 1);
        q.r0   = 32'h1000 + 32'(k);
        q.r1   = 32'h2000 + 32'(k);
        return q;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i      = 1'b0;
        dp_valid_i   = 1'b0;
        dp_req_i     = '0;
        dp_rid_i     = '0;
        dp_rdy_i     = 2'b11;
        wkup_valid_i = '0;
        wkup_rid_i   = '0;
        wkup_data_i  = '0;
    endtask

    task automatic disp(input iq_fcc_req_t q, input logic [5:0] rid1, input logic [5:0] rid0,
                        input logic [1:0] rdy);
        dp_valid_i = 1'b1;
        dp_req_i   = q;
        dp_rid_i   = {rid1, rid0};
        dp_rdy_i   = rdy;
    endtask

    // One clock with the scoreboard following both handshakes as seen by the queue.
    task automatic cycle_sb();
        if (ex_req_valid_o && ex_req_ready_i) begin
            if (exp_q.size() == 0) chk("sb_extra_issue", 1, 0);
            else                   chk("sb_order", ex_req_o, exp_q.pop_front());
            n_pop++;
        end
        if (dp_valid_i && dp_ready_o) begin
            exp_q.push_back(dp_req_i);
            n_push++;
            seq++;
        end
        tick();
    endtask

    initial begin
        idle();
        ex_req_ready_i = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", ex_req_valid_o, 0);
        chk("rst_dp_ready", dp_ready_o, 1);

        // Single ready op: issues one cycle after dispatch.
        ex_req_ready_i = 1'b1;
        r = mk(1);
        disp(r, 6'd0, 6'd0, 2'b11);
        tick();
        idle();
        chk("t1_valid", ex_req_valid_o, 1);
        chk("t1_payload", ex_req_o, r);
        tick();
        chk("t1_empty_valid", ex_req_valid_o, 0);
        chk("t1_empty_ready", dp_ready_o, 1);

        // Late operand r0 via wakeup port 1.
        r = mk(2); r.op = FCC_FCMP; r.r0 = 32'h0;
        disp(r, 6'd0, 6'd5, 2'b10);
        tick();
        idle();
        chk("t2_wait0", ex_req_valid_o, 0);
        tick();
        chk("t2_wait1", ex_req_valid_o, 0);
        wkup_valid_i = 2'b11;
        wkup_rid_i   = {6'd5, 6'd7};
        wkup_data_i  = {32'h3f800000, 32'hdeadbeef};
        tick();
        idle();
        r.r0 = 32'h3f800000;
        chk("t2_valid", ex_req_valid_o, 1);
        chk("t2_payload", ex_req_o, r);
        tick();
        chk("t2_popped", ex_req_valid_o, 0);

        // Two ports hit the same tag: the lower port's data is captured.
        r = mk(3); r.r0 = 32'h0;
        disp(r, 6'd0, 6'd3, 2'b10);
        tick();
        idle();
        wkup_valid_i = 2'b11;
        wkup_rid_i   = {6'd3, 6'd3};
        wkup_data_i  = {32'h22222222, 32'h11111111};
        tick();
        idle();
        chk("prio_valid", ex_req_valid_o, 1);
        chk("prio_r0", ex_req_o.r0, 32'h11111111);
        tick();

        // Write-time bypass: wakeup coincides with dispatch.
        r = mk(4); r.r1 = 32'h0;
        disp(r, 6'd9, 6'd0, 2'b01);
        wkup_valid_i = 2'b01;
        wkup_rid_i   = {6'd0, 6'd9};
        wkup_data_i  = {32'h0, 32'h40000000};
        tick();
        idle();
        r.r1 = 32'h40000000;
        chk("t3_valid", ex_req_valid_o, 1);
        chk("t3_payload", ex_req_o, r);
        tick();
        chk("t3_popped", ex_req_valid_o, 0);

        // Fill with the engine stalled, then stream across the pointer wrap.
        n_push = 0; n_pop = 0; seq = 10;
        ex_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(mk(seq), 6'd0, 6'd0, 2'b11);
            cycle_sb();
            chk($sformatf("fill_dp_ready%0d", k), dp_ready_o, (k < 3) ? 1 : 0);
        end
        idle();
        cycle_sb();
        chk("hold_valid", ex_req_valid_o, 1);
        chk("hold_payload", ex_req_o, mk(10));
        chk("hold_full", dp_ready_o, 0);
        ex_req_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            disp(mk(seq), 6'd0, 6'd0, 2'b11);
            cycle_sb();
        end
        idle();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle_sb();
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_valid_end", ex_req_valid_o, 0);
        chk("wrap_push_cnt", n_push, 11);
        chk("wrap_pop_cnt", n_pop, 11);

        // Blocked head keeps a ready younger entry waiting.
        ra = mk(40); ra.r0 = 32'h0;
        rb = mk(41);
        disp(ra, 6'd0, 6'd12, 2'b10);
        tick();
        disp(rb, 6'd0, 6'd0, 2'b11);
        tick();
        idle();
        chk("blk_valid0", ex_req_valid_o, 0);
        tick();
        chk("blk_valid1", ex_req_valid_o, 0);
        wkup_valid_i = 2'b10;
        wkup_rid_i   = {6'd12, 6'd0};
        wkup_data_i  = {32'h0000aaaa, 32'h0};
        tick();
        idle();
        ra.r0 = 32'h0000aaaa;
        chk("blk_first", ex_req_o, ra);
        chk("blk_first_v", ex_req_valid_o, 1);
        tick();
        chk("blk_second", ex_req_o, rb);
        chk("blk_second_v", ex_req_valid_o, 1);
        tick();
        chk("blk_empty", ex_req_valid_o, 0);

        // Flush a full queue with a dispatch in the same cycle.
        ex_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(mk(50 + k), 6'd0, 6'd0, 2'b11);
            tick();
        end
        chk("fl_full", dp_ready_o, 0);
        chk("fl_valid_pre", ex_req_valid_o, 1);
        disp(mk(60), 6'd0, 6'd0, 2'b11);
        flush_i = 1'b1;
        ex_req_ready_i = 1'b1;
        tick();
        idle();
        chk("fl_valid", ex_req_valid_o, 0);
        chk("fl_dp_ready", dp_ready_o, 1);
        tick();
        chk("fl_dropped", ex_req_valid_o, 0);

        // Flush beats an acceptable dispatch into a partly filled queue.
        ex_req_ready_i = 1'b0;
        disp(mk(61), 6'd0, 6'd0, 2'b11);
        tick();
        disp(mk(62), 6'd0, 6'd0, 2'b11);
        flush_i = 1'b1;
        tick();
        idle();
        tick();
        chk("fl2_valid", ex_req_valid_o, 0);
        ex_req_ready_i = 1'b1;
        disp(mk(63), 6'd0, 6'd0, 2'b11);
        tick();
        idle();
        chk("fl2_refill", ex_req_o, mk(63));
        chk("fl2_refill_v", ex_req_valid_o, 1);
        tick();

        // Reset mid-stream discards a held head.
        ex_req_ready_i = 1'b0;
        disp(mk(70), 6'd0, 6'd0, 2'b11);
        tick();
        disp(mk(71), 6'd0, 6'd0, 2'b11);
        tick();
        idle();
        chk("mrst_pre", ex_req_valid_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", ex_req_valid_o, 0);
        chk("mrst_dp_ready", dp_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
